// File: rtl/bcd_seg_scan_if.sv
// Digit bus between the ripple-counter consumer and its environment.
// master drives the raw units code; slave returns the filtered count and display drive.
interface bcd_seg_scan_if;
   logic [3:0] Din;
   logic [3:0] Units;
   logic [3:0] Tens;
   logic       Ovf;
   logic       Err;
   logic [6:0] Seg;
   logic [1:0] Dig;

   modport master (output Din, input Units, Tens, Ovf, Err, Seg, Dig);
   modport slave  (input Din, output Units, Tens, Ovf, Err, Seg, Dig);
endinterface

// File: rtl/bcd_seg_scan.sv
// Resync + stability-filter a ripple BCD digit, extend to two decades, scan a 2-digit 7-seg display.
// Latency: a clean Din change reaches Units STABLE+2 CK edges later; no backpressure, Din is sampled every cycle.
module bcd_seg_scan #(
   parameter int STABLE   = 2,
   parameter int SCAN_DIV = 4
) (
   input logic           CK,
   input logic           Clear,
   bcd_seg_scan_if.slave bus
);

   logic [3:0] s1, s2, p, st, st_nxt;
   logic [3:0] units_q, tens_q, units_nxt, tens_nxt;
   logic       ovf_q, err_q, ovf_nxt, err_nxt;
   logic [7:0] presc, presc_nxt;
   logic [1:0] dig_q, dig_nxt;
   logic [6:0] seg_q, seg_nxt;
   logic       reach, accept, wrap;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b1000000;
      endcase
   endfunction

   always_comb begin
      st_nxt    = st;
      units_nxt = units_q;
      tens_nxt  = tens_q;
      ovf_nxt   = ovf_q;
      err_nxt   = err_q;

      if (s2 != p)
         st_nxt = 4'd1;
      else if (st != 4'(STABLE))
         st_nxt = st + 4'd1;

      // With STABLE==1 the first differing sample is already enough.
      reach  = (s2 != p) ? (STABLE == 1) : (st == 4'(STABLE - 1));
      accept = reach && (s2 != units_q);

      if (accept) begin
         if (s2 > 4'd9) begin
            err_nxt = 1'b1;
         end else begin
            units_nxt = s2;
            if (units_q == 4'd9 && s2 == 4'd0) begin
               if (tens_q == 4'd9) begin
                  tens_nxt = 4'd0;
                  ovf_nxt  = 1'b1;
               end else begin
                  tens_nxt = tens_q + 4'd1;
               end
            end
         end
      end

      wrap      = (presc == 8'(SCAN_DIV - 1));
      presc_nxt = wrap ? 8'd0 : presc + 8'd1;
      dig_nxt   = wrap ? {dig_q[0], dig_q[1]} : dig_q;
      // Seg follows the post-edge selection and post-edge digit values.
      seg_nxt   = decode(dig_nxt[0] ? units_nxt : tens_nxt);
   end

   always_ff @(posedge CK or posedge Clear) begin
      if (Clear) begin
         s1      <= 4'd0;
         s2      <= 4'd0;
         p       <= 4'd0;
         st      <= 4'd0;
         units_q <= 4'd0;
         tens_q  <= 4'd0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         presc   <= 8'd0;
         dig_q   <= 2'b01;
         seg_q   <= 7'b0111111;
      end else begin
         s1      <= bus.Din;
         s2      <= s1;
         p       <= s2;
         st      <= st_nxt;
         units_q <= units_nxt;
         tens_q  <= tens_nxt;
         ovf_q   <= ovf_nxt;
         err_q   <= err_nxt;
         presc   <= presc_nxt;
         dig_q   <= dig_nxt;
         seg_q   <= seg_nxt;
      end
   end

   assign bus.Units = units_q;
   assign bus.Tens  = tens_q;
   assign bus.Ovf   = ovf_q;
   assign bus.Err   = err_q;
   assign bus.Seg   = seg_q;
   assign bus.Dig   = dig_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomised scoreboard bench for bcd_seg_scan with STABLE=2, SCAN_DIV=4.
// Stimulus pushes expected {Units,Tens,Ovf,Err} states; a monitor pops one per observed change.
module tb_bcd_seg_scan;

   logic CK    = 1'b0;
   logic Clear = 1'b0;

   bcd_seg_scan_if bus ();

   bcd_seg_scan #(.STABLE(2), .SCAN_DIV(4)) dut (
      .CK    (CK),
      .Clear (Clear),
      .bus   (bus)
   );

   always #5 CK = ~CK;

   typedef struct packed {
      logic [3:0] u;
      logic [3:0] t;
      logic       o;
      logic       e;
   } state_t;

   state_t     exp_q[$];
   state_t     m;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         ncyc  = 0;
   logic [3:0] cur_din;
   logic [6:0] glyph [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   // Edges seen since Clear last fell; the display phase follows from it.
   always @(posedge CK or posedge Clear) begin
      if (Clear) ncyc = 0;
      else       ncyc = ncyc + 1;
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] glyph_of(input logic [3:0] d);
      if (d > 4'd9) return 7'b1000000;
      return glyph[int'(d)];
   endfunction

   task automatic model_apply(input logic [3:0] v);
      state_t prev = m;
      int     t    = int'(m.t);
      if (v > 4'd9) begin
         m.e = 1'b1;
      end else begin
         if (m.u == 4'd9 && v == 4'd0) begin
            t = (t + 1) % 10;
            if (t == 0) m.o = 1'b1;
         end
         m.u = v;
         m.t = 4'(t);
      end
      if (m != prev) exp_q.push_back(m);
   endtask

   task automatic hold(input logic [3:0] v, input int n);
      bus.Din = v;
      cur_din = v;
      repeat (n) @(negedge CK);
   endtask

   task automatic put(input logic [3:0] v, input int n);
      model_apply(v);
      hold(v, n);
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(negedge CK);
         k++;
      end
      chk("drain_pending", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_clear(input string tag);
      int k = 0;
      while (((ncyc / 4) % 2) != 1 && k < 10) begin
         @(negedge CK);
         k++;
      end
      #2 Clear = 1'b1;
      bus.Din = 4'd0;
      cur_din = 4'd0;
      m       = '0;
      #1;
      chk({tag, "_dig"},   bus.Dig,   2'b01);
      chk({tag, "_seg"},   bus.Seg,   7'b0111111);
      chk({tag, "_units"}, bus.Units, 0);
      chk({tag, "_tens"},  bus.Tens,  0);
      chk({tag, "_flags"}, {bus.Ovf, bus.Err}, 0);
      #1 Clear = 1'b0;
   endtask

   task automatic monitor();
      state_t     last = '0;
      state_t     cur;
      state_t     e;
      logic [3:0] su = 4'd0;
      logic [3:0] tn = 4'd0;
      logic [1:0] dexp;
      forever begin
         @(negedge CK or posedge Clear);
         if (Clear) begin
            last = '0;
            su   = 4'd0;
            tn   = 4'd0;
         end else begin
            cur = {bus.Units, bus.Tens, bus.Ovf, bus.Err};
            if (cur != last) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_change", int'(cur), int'(last));
               end else begin
                  e = exp_q.pop_front();
                  chk("state", int'(cur), int'(e));
                  su = e.u;
                  tn = e.t;
               end
               last = cur;
            end
            dexp = (((ncyc / 4) % 2) == 1) ? 2'b10 : 2'b01;
            chk("dig", bus.Dig, dexp);
            chk("seg", bus.Seg, glyph_of(dexp[0] ? su : tn));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] v, g;
      bus.Din = 4'd0;
      cur_din = 4'd0;
      m       = '0;
      fork
         monitor();
      join_none

      // Asynchronous reset before any clock edge.
      #1 Clear = 1'b1;
      #2;
      chk("rst_units", bus.Units, 0);
      chk("rst_tens",  bus.Tens,  0);
      chk("rst_flags", {bus.Ovf, bus.Err}, 0);
      chk("rst_dig",   bus.Dig,   2'b01);
      chk("rst_seg",   bus.Seg,   7'b0111111);
      #3 Clear = 1'b0;

      // Latency: 0->3 lands on the 4th rising edge.
      @(negedge CK);
      model_apply(4'd3);
      bus.Din = 4'd3;
      cur_din = 4'd3;
      for (int i = 1; i <= 4; i++) begin
         @(negedge CK);
         chk($sformatf("latency_edge%0d", i), bus.Units, (i == 4) ? 3 : 0);
      end
      hold(4'd3, 2);

      // Glitch rejection, invalid code, carry, scan pattern.
      put(4'd1, 6);
      hold(4'd0, 1);
      put(4'd2, 6);
      put(4'hA, 6);
      put(4'd0, 6);
      put(4'd9, 6);
      put(4'hA, 6);
      put(4'd0, 6);
      put(4'd9, 6);
      put(4'd0, 6);
      put(4'd7, 20);
      drain();
      chk("scan_tens", bus.Tens, 2);
      do_clear("midscan_clr");

      // Randomised sequence with ripple glitches.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: begin
               g = 4'($urandom_range(0, 15));
               hold(g, 1);
            end
            1: begin
               v = cur_din;
               #2 bus.Din = 4'($urandom_range(0, 15));
               #2 bus.Din = v;
            end
            default: ;
         endcase
         if ($urandom_range(0, 2) == 0)
            v = 4'((int'(m.u) + 1) % 10);
         else if ($urandom_range(0, 9) == 0)
            v = 4'($urandom_range(10, 15));
         else
            v = 4'($urandom_range(0, 9));
         put(v, $urandom_range(3, 7));
      end
      drain();
      do_clear("rand_clr");

      // 100 full decades: tens wraps back to 0 and Ovf sticks.
      for (int d = 0; d < 100; d++) begin
         for (int k = 1; k <= 9; k++) put(4'(k), 6);
         put(4'd0, 6);
      end
      drain();
      chk("decades_tens",  bus.Tens,  0);
      chk("decades_units", bus.Units, 0);
      chk("decades_ovf",   bus.Ovf,   1);
      chk("decades_err",   bus.Err,   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
